// File: rtl/pulse_rate_meter_pkg.sv
// Shared types and helpers for the pulse_rate_meter block.
package pulse_rate_meter_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, REPORT} prm_state_t;

    // Width of the window counter; never narrower than one bit.
    function automatic int unsigned prm_win_w(input int unsigned window_cycles);
        return (window_cycles > 1) ? $clog2(window_cycles) : 1;
    endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for the pulse stream, with an optional 2-flop input
// synchronizer enabled by PULSE_RATE_METER_SYNC_EN.
module pulse_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pulse_i,
    output logic event_o
);

    logic pulse_s;
    logic pulse_q;

`ifdef PULSE_RATE_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pulse_i};
        end
    end

    assign pulse_s = sync_q[1];
`else
    assign pulse_s = pulse_i;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_s;
        end
    end

    assign event_o = pulse_s & ~pulse_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts pulse rising edges per fixed window and reports each count on a
// valid/ready output. PULSE_RATE_METER_SYNC_EN adds an input synchronizer.
module pulse_rate_meter
    import pulse_rate_meter_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 100,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse,
    input  logic             count_ready,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      WIN_W    = prm_win_w(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    prm_state_t       state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;

    logic             pulse_event;
    logic             acc_sat;
    logic [CNT_W-1:0] acc_next;
    logic             ovf_next;

    pulse_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .pulse_i (pulse),
        .event_o (pulse_event)
    );

    // Accumulator value including this cycle's event, saturating.
    assign acc_sat  = (acc_q == CNT_MAX);
    assign acc_next = (pulse_event && !acc_sat) ? acc_q + CNT_W'(1) : acc_q;
    assign ovf_next = ovf_acc_q | (pulse_event & acc_sat);

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                win_d     = '0;
                acc_d     = '0;
                ovf_acc_d = 1'b0;
                if (enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    // Abort: partial window is discarded.
                    state_d   = IDLE;
                    win_d     = '0;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                end else if (win_q == WIN_LAST) begin
                    count_d    = acc_next;
                    overflow_d = ovf_next;
                    valid_d    = 1'b1;
                    win_d      = '0;
                    acc_d      = '0;
                    ovf_acc_d  = 1'b0;
                    state_d    = REPORT;
                end else begin
                    win_d     = win_q + WIN_W'(1);
                    acc_d     = acc_next;
                    ovf_acc_d = ovf_next;
                end
            end
            REPORT: begin
                if (valid_q && count_ready) begin
                    valid_d = 1'b0;
                    state_d = enable ? COUNT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule
